// File: rtl/ram_sp_param_init.sv
// ram_sp_param_init: parametrised single-clock RAM with separate read and
// write ports, 1- or 2-cycle read latency, a defined read-during-write
// policy and a clear sequencer that fills the array with INIT_VALUE after
// reset or on a CLR request.
// Optional feature: define RAM_PARITY_EN to store an even-parity bit per
// word, add the PINJ fault-injection input and drive the sticky PERR flag.
module ram_sp_param_init #(
  parameter int             DW          = 16,
  parameter int             AW          = 8,
  parameter int             DEPTH       = 256,
  parameter int             PIPE        = 0,
  parameter int             WRITE_FIRST = 0,
  parameter logic [DW-1:0]  INIT_VALUE  = '0
) (
  input  logic          RWCLK,
  input  logic          RESET,
  input  logic          WEN,
  input  logic          REN,
  input  logic [AW-1:0] WADDR,
  input  logic [AW-1:0] RADDR,
  input  logic [DW-1:0] WD,
  input  logic          CLR,
`ifdef RAM_PARITY_EN
  input  logic          PINJ,
`endif
  output logic [DW-1:0] RD,
  output logic          RVALID,
  output logic          BUSY,
  output logic          PERR
);

  // Index width of the array; addresses are range-checked before use.
  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
`ifdef RAM_PARITY_EN
  localparam int          MW      = DW + 1;
  localparam logic [MW-1:0] INIT_WORD = {^INIT_VALUE, INIT_VALUE};
`else
  localparam int          MW      = DW;
  localparam logic [MW-1:0] INIT_WORD = INIT_VALUE;
`endif

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   cnt, cnt_nx;
  logic [MW-1:0]   mem [DEPTH];

  logic            waddr_ok, raddr_ok, rd_fire, rd_perr;
  logic [MW-1:0]   wr_word, byp_word, rd_word, mem_wword;
  logic [IW-1:0]   mem_widx;
  logic            mem_we;

  logic [DW-1:0]   s1_data, out_data;
  logic            s1_valid, s1_perr, out_valid;
  logic            last_in_valid, last_in_perr, perr_q;

  assign waddr_ok = ({1'b0, WADDR} < DEPTH_W);
  assign raddr_ok = ({1'b0, RADDR} < DEPTH_W);
  assign rd_fire  = (state == ST_RUN) && !CLR && REN;
  assign BUSY     = (state == ST_INIT);

`ifdef RAM_PARITY_EN
  assign wr_word  = {^WD ^ PINJ, WD};
  assign byp_word = {^WD, WD};
  assign rd_perr  = ^rd_word;
`else
  assign wr_word  = WD;
  assign byp_word = WD;
  assign rd_perr  = 1'b0;
`endif

  // State and clear-counter register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge RWCLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic: sweep the array in INIT, leave for RUN after the last word.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_INIT: begin
        if (CLR) begin
          cnt_nx = '0;
        end else if (cnt == IW'(DEPTH - 1)) begin
          state_nx = ST_RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        if (CLR) begin
          state_nx = ST_INIT;
          cnt_nx   = '0;
        end
      end
    endcase
  end

  // Write-port select: sweep writes in INIT, user writes in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = '0;
    mem_wword = '0;
    if (state == ST_INIT) begin
      mem_we    = 1'b1;
      mem_widx  = cnt;
      mem_wword = INIT_WORD;
    end else if (!CLR && WEN && waddr_ok) begin
      mem_we    = 1'b1;
      mem_widx  = WADDR[IW-1:0];
      mem_wword = wr_word;
    end
  end

  // Array write.
  // NOTE: the array has no reset; it is initialised by the clear sweep so it can map to block RAM.
  always_ff @(posedge RWCLK) begin
    if (mem_we) mem[mem_widx] <= mem_wword;
  end

  // Read word: out-of-range reads return zero, same-address write-first reads bypass WD.
  always_comb begin
    rd_word = '0;
    if (raddr_ok) begin
      if ((WRITE_FIRST != 0) && WEN && (WADDR == RADDR))
        rd_word = byp_word;
      else
        rd_word = mem[RADDR[IW-1:0]];
    end
  end

  // First read stage: captures the array output for an accepted read.
  always_ff @(posedge RWCLK or posedge RESET) begin
    if (RESET) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_perr  <= 1'b0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) begin
        s1_data <= rd_word[DW-1:0];
        s1_perr <= rd_perr;
      end
    end
  end

  generate
    if (PIPE != 0) begin : g_pipe
      logic [DW-1:0] s2_data;
      logic          s2_valid;

      // Optional output register adding one cycle of read latency.
      always_ff @(posedge RWCLK or posedge RESET) begin
        if (RESET) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign out_data      = s2_data;
      assign out_valid     = s2_valid;
      assign last_in_valid = s1_valid;
      assign last_in_perr  = s1_perr;
    end else begin : g_nopipe
      assign out_data      = s1_data;
      assign out_valid     = s1_valid;
      assign last_in_valid = rd_fire;
      assign last_in_perr  = rd_perr;
    end
  endgenerate

  // Sticky parity flag, set on the edge that raises RVALID, cleared on entry to INIT.
  always_ff @(posedge RWCLK or posedge RESET) begin
    if (RESET)
      perr_q <= 1'b0;
    else if ((state == ST_RUN) && CLR)
      perr_q <= 1'b0;
    else if (last_in_valid && last_in_perr)
      perr_q <= 1'b1;
  end

  assign RD     = out_data;
  assign RVALID = out_valid;
`ifdef RAM_PARITY_EN
  assign PERR   = perr_q;
`else
  assign PERR   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sp_param_init.sv
// Testbench for ram_sp_param_init: two instances sharing stimulus.
//   dut_a: DEPTH=256, INIT=A5A5, PIPE=0, WRITE_FIRST=1
//   dut_b: DEPTH=200, INIT=0000, PIPE=1, WRITE_FIRST=0
module tb_ram_sp_param_init;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen, ren, clr, pinj;
  logic [7:0]  waddr, raddr;
  logic [15:0] wd;
  logic [15:0] rd_a, rd_b;
  logic        rv_a, rv_b, busy_a, busy_b, perr_a, perr_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_sp_param_init #(
    .DW(16), .AW(8), .DEPTH(256), .PIPE(0), .WRITE_FIRST(1), .INIT_VALUE(16'hA5A5)
  ) dut_a (
    .RWCLK(clk), .RESET(rst), .WEN(wen), .REN(ren), .WADDR(waddr), .RADDR(raddr),
    .WD(wd), .CLR(clr),
`ifdef RAM_PARITY_EN
    .PINJ(pinj),
`endif
    .RD(rd_a), .RVALID(rv_a), .BUSY(busy_a), .PERR(perr_a)
  );

  ram_sp_param_init #(
    .DW(16), .AW(8), .DEPTH(200), .PIPE(1), .WRITE_FIRST(0), .INIT_VALUE(16'h0000)
  ) dut_b (
    .RWCLK(clk), .RESET(rst), .WEN(wen), .REN(ren), .WADDR(waddr), .RADDR(raddr),
    .WD(wd), .CLR(clr),
`ifdef RAM_PARITY_EN
    .PINJ(pinj),
`endif
    .RD(rd_b), .RVALID(rv_b), .BUSY(busy_b), .PERR(perr_b)
  );

  typedef struct {
    logic        wen;
    logic        ren;
    logic [7:0]  waddr;
    logic [7:0]  raddr;
    logic [15:0] wd;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [14];
  vec_t post [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // One transaction, called at a negedge; checks dut_a after 1 edge, dut_b after 2.
  task automatic apply(input vec_t v, input string tag);
    wen = v.wen; ren = v.ren; waddr = v.waddr; raddr = v.raddr; wd = v.wd;
    @(negedge clk);
    wen = 1'b0; ren = 1'b0;
    if (v.ren) begin
      check({tag, " a rvalid"}, 32'(rv_a), 32'd1);
      check({tag, " a rd"}, 32'(rd_a), 32'(v.exp_a));
      check({tag, " b rvalid early"}, 32'(rv_b), 32'd0);
    end
    @(negedge clk);
    if (v.ren) begin
      check({tag, " a rvalid drop"}, 32'(rv_a), 32'd0);
      check({tag, " b rvalid"}, 32'(rv_b), 32'd1);
      check({tag, " b rd"}, 32'(rd_b), 32'(v.exp_b));
    end
  endtask

  // Counts negedges until dut_a leaves INIT; also records when dut_b left.
  task automatic count_busy(input string tag);
    int na, nb;
    na = 0; nb = 0;
    do begin
      @(negedge clk);
      na++;
      if (!busy_b && nb == 0) nb = na;
    end while (busy_a && na < 1000);
    check({tag, " a busy cycles"}, 32'(na), 32'd256);
    check({tag, " b busy cycles"}, 32'(nb), 32'd200);
  endtask

  initial begin
    //            wen   ren   waddr  raddr  wd        exp_a     exp_b
    vecs[0]  = '{1'b0, 1'b1, 8'h00, 8'h00, 16'h0000, 16'hA5A5, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 8'd128,16'h0000, 16'hA5A5, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 8'd255,16'h0000, 16'hA5A5, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, 8'h10, 8'h00, 16'h1234, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 8'h10, 16'h0000, 16'h1234, 16'h1234};
    vecs[5]  = '{1'b1, 1'b1, 8'h20, 8'h20, 16'hBEEF, 16'hBEEF, 16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 8'h20, 16'h0000, 16'hBEEF, 16'hBEEF};
    vecs[7]  = '{1'b1, 1'b0, 8'd210,8'h00, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 8'd210,16'h0000, 16'hFFFF, 16'h0000};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 8'd199,16'h0000, 16'hA5A5, 16'h0000};
    vecs[10] = '{1'b1, 1'b1, 8'h30, 8'h31, 16'h5555, 16'hA5A5, 16'h0000};
    vecs[11] = '{1'b0, 1'b1, 8'h00, 8'h30, 16'h0000, 16'h5555, 16'h5555};
    vecs[12] = '{1'b1, 1'b0, 8'd199,8'h00, 16'h7777, 16'h0000, 16'h0000};
    vecs[13] = '{1'b0, 1'b1, 8'h00, 8'd199,16'h0000, 16'h7777, 16'h7777};

    post[0]  = '{1'b0, 1'b1, 8'h00, 8'h10, 16'h0000, 16'hA5A5, 16'h0000};
    post[1]  = '{1'b0, 1'b1, 8'h00, 8'h20, 16'h0000, 16'hA5A5, 16'h0000};
    post[2]  = '{1'b0, 1'b1, 8'h00, 8'h30, 16'h0000, 16'hA5A5, 16'h0000};
    post[3]  = '{1'b0, 1'b1, 8'h00, 8'd199,16'h0000, 16'hA5A5, 16'h0000};

    rst = 1'b1; wen = 1'b0; ren = 1'b0; clr = 1'b0; pinj = 1'b0;
    waddr = '0; raddr = '0; wd = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset a busy",   32'(busy_a), 32'd1);
    check("reset a rvalid", 32'(rv_a),   32'd0);
    check("reset a rd",     32'(rd_a),   32'd0);
    check("reset a perr",   32'(perr_a), 32'd0);
    check("reset b busy",   32'(busy_b), 32'd1);
    check("reset b rvalid", 32'(rv_b),   32'd0);

    // Initial sweep length.
    rst = 1'b0;
    count_busy("init");

    // Table-driven transactions.
    for (int i = 0; i < 14; i++) apply(vecs[i], $sformatf("v%0d", i));

    // Back-to-back reads, one result per cycle.
    ren = 1'b1; raddr = 8'h10;
    @(negedge clk);
    check("b2b a0", 32'(rd_a), 32'h1234); check("b2b a0 v", 32'(rv_a), 32'd1);
    raddr = 8'h20;
    @(negedge clk);
    check("b2b a1", 32'(rd_a), 32'hBEEF); check("b2b a1 v", 32'(rv_a), 32'd1);
    check("b2b b0", 32'(rd_b), 32'h1234); check("b2b b0 v", 32'(rv_b), 32'd1);
    raddr = 8'h30;
    @(negedge clk);
    ren = 1'b0;
    check("b2b a2", 32'(rd_a), 32'h5555); check("b2b a2 v", 32'(rv_a), 32'd1);
    check("b2b b1", 32'(rd_b), 32'hBEEF); check("b2b b1 v", 32'(rv_b), 32'd1);
    @(negedge clk);
    check("b2b a idle v", 32'(rv_a), 32'd0); check("b2b a hold", 32'(rd_a), 32'h5555);
    check("b2b b2", 32'(rd_b), 32'h5555); check("b2b b2 v", 32'(rv_b), 32'd1);
    @(negedge clk);
    check("b2b b idle v", 32'(rv_b), 32'd0);

    // CLR with a read in flight, then reset mid-sweep.
    ren = 1'b1; raddr = 8'h10;
    @(negedge clk);
    ren = 1'b0; clr = 1'b1; wen = 1'b1; waddr = 8'h40; wd = 16'hDEAD;
    check("clr a rd", 32'(rd_a), 32'h1234); check("clr a busy pre", 32'(busy_a), 32'd0);
    @(negedge clk);
    clr = 1'b0; wen = 1'b0;
    check("clr a busy", 32'(busy_a), 32'd1); check("clr b busy", 32'(busy_b), 32'd1);
    check("clr b inflight v", 32'(rv_b), 32'd1); check("clr b inflight rd", 32'(rd_b), 32'h1234);
    repeat (50) @(negedge clk);
    check("mid-init a busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    #1;
    check("rst a busy", 32'(busy_a), 32'd1);
    check("rst a rd", 32'(rd_a), 32'd0);
    check("rst b rd", 32'(rd_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_busy("reinit");
    for (int i = 0; i < 4; i++) apply(post[i], $sformatf("post%0d", i));
    check("perr a idle", 32'(perr_a), 32'd0);

`ifdef RAM_PARITY_EN
    // Parity fault injection, sticky flag, cleared by CLR.
    wen = 1'b1; waddr = 8'h05; wd = 16'h0001; pinj = 1'b1;
    @(negedge clk);
    wen = 1'b0; pinj = 1'b0; ren = 1'b1; raddr = 8'h05;
    @(negedge clk);
    ren = 1'b0;
    check("par a rvalid", 32'(rv_a), 32'd1); check("par a perr", 32'(perr_a), 32'd1);
    @(negedge clk);
    check("par a sticky", 32'(perr_a), 32'd1);
    check("par b rvalid", 32'(rv_b), 32'd1); check("par b perr", 32'(perr_b), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("par a cleared", 32'(perr_a), 32'd0); check("par b cleared", 32'(perr_b), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_sp_param_init.md
Name: ram_sp_param_init

Overview:
- Parametrised successor of the CoreABC 256x16 instruction/data RAM wrapper.
- Single-clock memory with separate read and write ports, configurable width and depth, and selectable read latency (1 or 2 cycles).
- Defined read-during-write policy and a hardware clear sequencer that fills the array with INIT_VALUE after reset or on request.
- Sits between the CoreABC sequencer/APB logic and the inferred RAM array.

Parameters:
- DW, 16, data width in bits (1..32).
- AW, 8, address width in bits.
- DEPTH, 256, number of words; 2 <= DEPTH <= 2**AW.
- PIPE, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.
- WRITE_FIRST, 0, 1 = same-address read-during-write returns WD; 0 = returns old contents.
- INIT_VALUE, 0, DW-bit value written to every word by the clear sequencer.

Ports:
- RWCLK  in  1  single clock for all logic and the array; rising edge.
- RESET  in  1  asynchronous, active-high reset.
- WEN  in  1  write enable, active high.
- REN  in  1  read enable, active high.
- WADDR  in  AW  write address.
- RADDR  in  AW  read address.
- WD  in  DW  write data.
- CLR  in  1  single-cycle request to re-run the clear sequence.
- RD  out  DW  read data.
- RVALID  out  1  one-cycle strobe; RD holds new read data.
- BUSY  out  1  high while the clear sequence runs.
- PERR  out  1  sticky parity error; present only with RAM_PARITY_EN, otherwise tied 0.

Behaviour:
- Reset (RESET=1, asynchronous): RD=0, RVALID=0, BUSY=1, PERR=0, pipeline registers=0, FSM=INIT, clear counter=0. RESET does not touch array contents directly.
- FSM states: INIT and RUN.
- INIT:
  - Each cycle writes INIT_VALUE to mem[cnt] and increments cnt.
  - After the write to DEPTH-1, goes to RUN on the same edge.
  - The sweep takes exactly DEPTH cycles after RESET deasserts; BUSY drops on the edge that enters RUN.
  - WEN and REN are ignored; no RVALID is issued.
  - CLR in INIT restarts cnt at 0.
- RUN:
  - CLR=1 goes to INIT with cnt=0 and BUSY=1 from the next cycle. Any WEN/REN in the same cycle is ignored. Reads in flight still complete.
  - WEN=1 with WADDR<DEPTH: mem[WADDR]<=WD on the edge. WADDR>=DEPTH: write dropped.
  - REN=1, PIPE=0: on edge N, RD<=mem[RADDR] and RVALID=1 during cycle N+1.
  - REN=1, PIPE=1: the same data appears one edge later; RVALID=1 during cycle N+2.
  - Back-to-back REN gives one result per cycle.
  - RADDR>=DEPTH: RD<=0, RVALID still asserted.
  - RD holds its last value when no read completes. RVALID is high for exactly one cycle per accepted read.
- Simultaneous WEN and REN, same address:
  - WRITE_FIRST=1: RD returns WD.
  - WRITE_FIRST=0: RD returns the prior contents.
  - Different addresses are independent.
- Reset mid-operation flushes the pipeline (RVALID=0) and restarts INIT.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Array width is DW+1; the extra bit stores even parity (^WD). INIT writes ^INIT_VALUE.
  - Extra input PINJ (1 bit): when high with WEN, the inverted parity bit is stored (fault injection).
  - On every completed read, a stored-parity mismatch sets PERR, aligned with RVALID.
  - PERR is sticky; cleared only by RESET or by entering INIT.
  - A WRITE_FIRST bypass read uses the computed parity of WD.
- Undefined: no parity storage, no PINJ port, PERR constant 0, array is DW wide.

Test Plan:
- Reset then release, DEPTH=256, INIT_VALUE=16'hA5A5 -> BUSY high for exactly 256 cycles. Reads of addresses 0, 128, 255 return 16'hA5A5 with RVALID one cycle later (PIPE=0).
- RUN, write 16'h1234 to 8'h10, then REN at 8'h10 next cycle -> RD=16'h1234 one cycle later (PIPE=0) or two cycles later (PIPE=1); RVALID single-cycle.
- WEN+REN same cycle at 8'h20 (old 16'h0000, WD=16'hBEEF) -> RD=16'hBEEF with WRITE_FIRST=1; RD=16'h0000 with WRITE_FIRST=0.
- DEPTH=200, AW=8: write 16'hFFFF to 8'd210, then read 8'd210 -> RD=0, RVALID=1; address 199 unaffected.
- CLR pulse in RUN after writes, then RESET asserted mid-INIT at cnt=50 -> BUSY stays high, the sweep restarts from 0, and all words equal INIT_VALUE afterwards.
- RAM_PARITY_EN: write 16'h0001 at 8'h05 with PINJ=1, then read -> PERR=1 with RVALID and stays 1; CLR clears it to 0.
